// File: rtl/mux2_8bit.sv
// Four-source priority selector (a > b > c > d) with a registered copy of the result
// and a sticky flag that records when more than one select was asserted.
module mux2_8bit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_addr,
  input  logic [WIDTH-1:0] a,
  input  logic             b_addr,
  input  logic [WIDTH-1:0] b,
  input  logic             c_addr,
  input  logic [WIDTH-1:0] c,
  input  logic             d_addr,
  input  logic [WIDTH-1:0] d,
  input  logic             clr_err,
  output logic [WIDTH-1:0] o,
  output logic [WIDTH-1:0] o_q,
  output logic             sel_any,
  output logic [1:0]       sel_idx,
  output logic             collision,
  output logic             collision_sticky
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             sticky_q, sticky_d;

  always_comb begin
    o       = '0;
    sel_idx = 2'd0;
    if (a_addr) begin
      o       = a;
      sel_idx = 2'd0;
    end else if (b_addr) begin
      o       = b;
      sel_idx = 2'd1;
    end else if (c_addr) begin
      o       = c;
      sel_idx = 2'd2;
    end else if (d_addr) begin
      o       = d;
      sel_idx = 2'd3;
    end
  end

  assign sel_any   = a_addr | b_addr | c_addr | d_addr;
  // Any pair of selects high means two or more are high.
  assign collision = (a_addr & (b_addr | c_addr | d_addr)) |
                     (b_addr & (c_addr | d_addr)) |
                     (c_addr & d_addr);

  always_comb begin
    data_d   = o;
    // A new collision takes precedence over a clear request on the same edge.
    sticky_d = collision | (sticky_q & ~clr_err);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q   <= '0;
      sticky_q <= 1'b0;
    end else begin
      data_q   <= data_d;
      sticky_q <= sticky_d;
    end
  end

  assign o_q              = data_q;
  assign collision_sticky = sticky_q;

endmodule

// File: tb/tb_mux2_8bit.sv
// Self-checking bench for mux2_8bit: directed scenarios followed by randomized
// traffic, all compared against a priority-scan reference model.
module tb_mux2_8bit;

  localparam int unsigned W = 8;

  logic         clk, reset, clr_err;
  logic         a_addr, b_addr, c_addr, d_addr;
  logic [W-1:0] a, b, c, d;
  logic [W-1:0] o, o_q;
  logic         sel_any, collision, collision_sticky;
  logic [1:0]   sel_idx;

  int unsigned  checks = 0;
  int unsigned  errors = 0;
  logic [W-1:0] exp_oq;
  logic         exp_st;

  mux2_8bit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .a_addr(a_addr), .a(a), .b_addr(b_addr), .b(b),
    .c_addr(c_addr), .c(c), .d_addr(d_addr), .d(d),
    .clr_err(clr_err),
    .o(o), .o_q(o_q), .sel_any(sel_any), .sel_idx(sel_idx),
    .collision(collision), .collision_sticky(collision_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: scan sources in priority order, count the asserted selects.
  function automatic int first_sel();
    logic s[4];
    s = '{a_addr, b_addr, c_addr, d_addr};
    for (int i = 0; i < 4; i++) if (s[i]) return i;
    return -1;
  endfunction

  function automatic int num_sel();
    return int'(a_addr) + int'(b_addr) + int'(c_addr) + int'(d_addr);
  endfunction

  function automatic logic [W-1:0] model_o();
    logic [W-1:0] src[4];
    int k;
    src = '{a, b, c, d};
    k = first_sel();
    return (k < 0) ? '0 : src[k];
  endfunction

  task automatic check_comb(input string tag);
    int k;
    k = first_sel();
    check({tag, ".o"}, 32'(o), 32'(model_o()));
    check({tag, ".sel_any"}, 32'(sel_any), 32'(k >= 0));
    check({tag, ".sel_idx"}, 32'(sel_idx), (k < 0) ? 32'd0 : 32'(k));
    check({tag, ".collision"}, 32'(collision), 32'(num_sel() >= 2));
  endtask

  task automatic tick(input string tag);
    logic [W-1:0] n_oq;
    logic         n_st;
    n_oq = model_o();
    n_st = (num_sel() >= 2) || (exp_st && !clr_err);
    @(posedge clk);
    #1;
    if (reset) begin
      exp_oq = '0;
      exp_st = 1'b0;
    end else begin
      exp_oq = n_oq;
      exp_st = n_st;
    end
    check({tag, ".o_q"}, 32'(o_q), 32'(exp_oq));
    check({tag, ".sticky"}, 32'(collision_sticky), 32'(exp_st));
  endtask

  task automatic set_sel(input logic sa, input logic sb, input logic sc, input logic sd);
    a_addr = sa; b_addr = sb; c_addr = sc; d_addr = sd;
  endtask

  task automatic pulse_reset(input string tag);
    #2 reset = 1'b1;
    exp_oq = '0;
    exp_st = 1'b0;
    #1;
    check({tag, ".rst_oq"}, 32'(o_q), 32'd0);
    check({tag, ".rst_st"}, 32'(collision_sticky), 32'd0);
    check({tag, ".rst_o"}, 32'(o), 32'(model_o()));
    #1 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; clr_err = 1'b0;
    set_sel(0, 0, 0, 0);
    a = 8'hAA; b = 8'hBB; c = 8'hCC; d = 8'hDD;
    exp_oq = '0; exp_st = 1'b0;
    #2;
    check("reset.o_q", 32'(o_q), 32'd0);
    check("reset.sticky", 32'(collision_sticky), 32'd0);
    set_sel(0, 1, 0, 0);
    #1 check("reset.comb_live", 32'(o), 32'hBB);
    set_sel(0, 0, 0, 0);
    @(negedge clk) reset = 1'b0;

    #1;
    check_comb("none");
    check("none.o_const", 32'(o), 32'h00);

    set_sel(1, 0, 0, 0); #1 check_comb("only_a"); check("only_a.o_const", 32'(o), 32'hAA);
    set_sel(0, 1, 0, 0); #1 check_comb("only_b"); check("only_b.o_const", 32'(o), 32'hBB);
    set_sel(0, 0, 1, 0); #1 check_comb("only_c"); check("only_c.o_const", 32'(o), 32'hCC);
    set_sel(0, 0, 0, 1); #1 check_comb("only_d"); check("only_d.o_const", 32'(o), 32'hDD);
    check("only_d.idx_const", 32'(sel_idx), 32'd3);
    set_sel(0, 0, 0, 0); #1 check("deassert_d.o", 32'(o), 32'h00);
    tick("idle");

    set_sel(0, 1, 0, 1); #1 check_comb("b_d");
    check("b_d.o_const", 32'(o), 32'hBB);
    check("b_d.coll_const", 32'(collision), 32'd1);
    tick("b_d");
    check("b_d.sticky_const", 32'(collision_sticky), 32'd1);

    clr_err = 1'b1; tick("setwins");
    check("setwins.sticky_const", 32'(collision_sticky), 32'd1);
    set_sel(0, 0, 0, 0); tick("clear");
    check("clear.sticky_const", 32'(collision_sticky), 32'd0);
    clr_err = 1'b0;

    set_sel(0, 0, 1, 0); tick("c_reg");
    check("c_reg.oq_const", 32'(o_q), 32'hCC);
    pulse_reset("c_rst");
    check("c_rst.o_const", 32'(o), 32'hCC);
    tick("after_rst");

    set_sel(1, 0, 0, 0); a = 8'h00; #1 check_comb("a00");
    tick("a00");
    a = 8'hFF; #1 check_comb("aFF");
    check("aFF.oq_hold", 32'(o_q), 32'h00);
    b = 8'h12; #1 check("unsel_change.o", 32'(o), 32'hFF);
    tick("aFF");
    check("aFF.oq_const", 32'(o_q), 32'hFF);

    for (int i = 0; i < 300; i++) begin
      logic [3:0] s;
      s = 4'($urandom_range(0, 15));
      set_sel(s[0], s[1], s[2], s[3]);
      a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); d = 8'($urandom);
      clr_err = ($urandom_range(0, 3) == 0);
      #1 check_comb("rnd");
      if (s[0] || s[1]) begin
        c = 8'($urandom); d = 8'($urandom);
        #1 check_comb("rnd_unsel");
      end
      tick("rnd");
      if ($urandom_range(0, 39) == 0) pulse_reset("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
